// File: rtl/non_restoring_divider.sv
// ---------------------------------------------------------------------------
// non_restoring_divider
//   Iterative radix-2 non-restoring divider for DIV/DIVU/REM/REMU.
//   One quotient bit is produced per cycle. A final fixup cycle corrects the
//   remainder and applies the result signs. Divide-by-zero and the signed
//   overflow case (most-negative / -1) finish in a single cycle.
//
// Ports
//   clk_i            : clock, rising edge
//   rst_n_i          : asynchronous active-low reset
//   data_valid_i     : operands valid (sampled only while ready_o=1)
//   dividend_i       : dividend
//   divisor_i        : divisor
//   signed_i         : 1 = two's-complement DIV/REM, 0 = DIVU/REMU
//   abort_i          : flush; cancels an operation in flight
//   quotient_o       : registered quotient, held until the next result
//   remainder_o      : registered remainder, held until the next result
//   divide_by_zero_o : divisor was zero (qualified by data_valid_o)
//   data_valid_o     : one-cycle result strobe
//   ready_o          : a new operation can be accepted this cycle
// ---------------------------------------------------------------------------
module non_restoring_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  signed_i,
  input  logic                  abort_i,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o,
  output logic                  divide_by_zero_o,
  output logic                  data_valid_o,
  output logic                  ready_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_FIXUP  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH:0]   pr_q, pr_d;          // signed partial remainder
  logic [DATA_WIDTH-1:0] quo_q, quo_d;        // dividend bits shift out, quotient bits shift in
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;        // divisor magnitude
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0] quotient_q, quotient_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic                  accept;
  logic [DATA_WIDTH-1:0] dvd_mag;
  logic [DATA_WIDTH-1:0] dvs_mag;
  logic [DATA_WIDTH:0]   pr_shift;
  logic [DATA_WIDTH:0]   pr_step;
  logic [DATA_WIDTH-1:0] quo_step;
  logic [DATA_WIDTH:0]   pr_fix;

  always_comb begin
    accept  = (state_q == S_IDLE) && data_valid_i && !abort_i;
    dvd_mag = (signed_i && dividend_i[DATA_WIDTH-1]) ? -dividend_i : dividend_i;
    dvs_mag = (signed_i && divisor_i[DATA_WIDTH-1])  ? -divisor_i  : divisor_i;

    // Shift the next dividend bit into the partial remainder, then subtract
    // when the old remainder was non-negative, add when it was negative.
    // The shifted value may wrap, but the sum always lands in [-M, M) so the
    // modular result is exact.
    pr_shift = {pr_q[DATA_WIDTH-1:0], quo_q[DATA_WIDTH-1]};
    pr_step  = pr_q[DATA_WIDTH] ? (pr_shift + {1'b0, dvs_q})
                                : (pr_shift - {1'b0, dvs_q});
    quo_step = {quo_q[DATA_WIDTH-2:0], ~pr_step[DATA_WIDTH]};

    // Final restore step: a negative remainder is one divisor too small.
    pr_fix = pr_q[DATA_WIDTH] ? (pr_q + {1'b0, dvs_q}) : pr_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pr_d        = pr_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (divisor_i == '0) begin
            quotient_d  = '1;
            remainder_d = dividend_i;
            dbz_d       = 1'b1;
            state_d     = S_DONE;
          end else if (signed_i && (dividend_i == INT_MIN) && (divisor_i == '1)) begin
            // The true quotient is not representable; it wraps to INT_MIN.
            quotient_d  = INT_MIN;
            remainder_d = '0;
            dbz_d       = 1'b0;
            state_d     = S_DONE;
          end else begin
            cnt_d     = CNT_W'(DATA_WIDTH - 1);
            pr_d      = '0;
            quo_d     = dvd_mag;
            dvs_d     = dvs_mag;
            neg_quo_d = signed_i && (dividend_i[DATA_WIDTH-1] ^ divisor_i[DATA_WIDTH-1]);
            neg_rem_d = signed_i && dividend_i[DATA_WIDTH-1];
            state_d   = S_DIVIDE;
          end
        end
      end

      S_DIVIDE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          pr_d  = pr_step;
          quo_d = quo_step;
          if (cnt_q == '0) begin
            state_d = S_FIXUP;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_FIXUP: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          pr_d        = pr_fix;
          quotient_d  = neg_quo_q ? -quo_q : quo_q;
          remainder_d = neg_rem_q ? -pr_fix[DATA_WIDTH-1:0] : pr_fix[DATA_WIDTH-1:0];
          dbz_d       = 1'b0;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pr_q        <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pr_q        <= pr_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign quotient_o       = quotient_q;
  assign remainder_o      = remainder_q;
  assign divide_by_zero_o = dbz_q;
  assign data_valid_o     = (state_q == S_DONE);
  assign ready_o          = (state_q == S_IDLE);

endmodule

// File: tb/tb_non_restoring_divider.sv
// ---------------------------------------------------------------------------
// tb_non_restoring_divider
//   Self-checking bench for non_restoring_divider (32-bit). Expected results
//   come from plain 64-bit integer division plus the divide-by-zero and
//   overflow rules. Inputs are driven 1 time unit after the rising edge and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_non_restoring_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_valid_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        signed_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        divide_by_zero_o;
  logic        data_valid_o;
  logic        ready_o;

  int checks = 0;
  int failures = 0;

  non_restoring_divider #(.DATA_WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .data_valid_i     (data_valid_i),
    .dividend_i       (dividend_i),
    .divisor_i        (divisor_i),
    .signed_i         (signed_i),
    .abort_i          (abort_i),
    .quotient_o       (quotient_o),
    .remainder_o      (remainder_o),
    .divide_by_zero_o (divide_by_zero_o),
    .data_valid_o     (data_valid_o),
    .ready_o          (ready_o)
  );

  always #5 clk = ~clk;

  // Reference: architectural DIV/DIVU/REM/REMU results and cycle latency.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz, output int lat);
    longint sa;
    longint sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    lat = 34;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (s) begin
      q = 32'(sa / sb); r = 32'(sa % sb);
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Drive one request; returns in the cycle after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    dividend_i = a; divisor_i = b; signed_i = s; data_valid_i = 1'b1;
    @(posedge clk); #1;
    data_valid_i = 1'b0;
  endtask

  // Watch for the result strobe, starting in cycle accept+start_k; lat=-1 if
  // none appears by cycle accept+60. early_ready flags ready_o before the strobe.
  task automatic wait_valid(input int start_k, output int lat, output logic early_ready,
                            output logic [31:0] q, output logic [31:0] r, output logic dz);
    lat = -1; early_ready = 1'b0; q = '0; r = '0; dz = 1'b0;
    for (int k = start_k; k <= 60; k++) begin
      @(negedge clk);
      if (data_valid_o) begin
        lat = k; q = quotient_o; r = remainder_o; dz = divide_by_zero_o;
        break;
      end
      if (ready_o) early_ready = 1'b1;
    end
  endtask

  task automatic test_reset();
    int lat; logic er; logic [31:0] q, r; logic dz;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (quotient_o !== 32'd0) begin failures++; $display("FAIL reset_quotient got=%h exp=0", quotient_o); end
    checks++; if (remainder_o !== 32'd0) begin failures++; $display("FAIL reset_remainder got=%h exp=0", remainder_o); end
    checks++; if (divide_by_zero_o !== 1'b0) begin failures++; $display("FAIL reset_dbz got=%b exp=0", divide_by_zero_o); end
    checks++; if (data_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", data_valid_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    // Release and offer an operation before the very first rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    dividend_i = 32'd9; divisor_i = 32'd3; signed_i = 1'b0; data_valid_i = 1'b1;
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    wait_valid(1, lat, er, q, r, dz);
    $display("op reset_first 9/3 lat=%0d q=%h r=%h", lat, q, r);
    checks++; if (lat !== 34) begin failures++; $display("FAIL first_edge_latency got=%0d exp=34", lat); end
    checks++; if (q !== 32'd3 || r !== 32'd0) begin failures++; $display("FAIL first_edge_result got=%h/%h exp=3/0", q, r); end
  endtask

  task automatic test_unsigned();
    int lat; logic er; logic [31:0] q, r; logic dz;
    start_op(32'd100, 32'd7, 1'b0);
    wait_valid(1, lat, er, q, r, dz);
    $display("op divu 100/7 lat=%0d q=%h r=%h", lat, q, r);
    checks++; if (lat !== 34) begin failures++; $display("FAIL divu_latency got=%0d exp=34", lat); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL divu_ready_busy got=%b exp=0", er); end
    checks++; if (q !== 32'd14) begin failures++; $display("FAIL divu_quotient got=%h exp=e", q); end
    checks++; if (r !== 32'd2) begin failures++; $display("FAIL divu_remainder got=%h exp=2", r); end
    checks++; if (dz !== 1'b0) begin failures++; $display("FAIL divu_dbz got=%b exp=0", dz); end
    @(negedge clk);
    checks++; if (data_valid_o !== 1'b0 || ready_o !== 1'b1) begin failures++;
      $display("FAIL divu_strobe_width got valid=%b ready=%b exp valid=0 ready=1", data_valid_o, ready_o); end
  endtask

  task automatic test_signed();
    int lat; logic er; logic [31:0] q, r; logic dz;
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_valid(1, lat, er, q, r, dz);
    $display("op div -7/2 lat=%0d q=%h r=%h", lat, q, r);
    checks++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin failures++;
      $display("FAIL div_neg_dividend got=%h/%h exp=fffffffd/ffffffff", q, r); end
    checks++; if (lat !== 34) begin failures++; $display("FAIL div_neg_latency got=%0d exp=34", lat); end
    start_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_valid(1, lat, er, q, r, dz);
    $display("op div 7/-2 lat=%0d q=%h r=%h", lat, q, r);
    checks++; if (q !== 32'hFFFF_FFFD || r !== 32'd1) begin failures++;
      $display("FAIL div_neg_divisor got=%h/%h exp=fffffffd/1", q, r); end
  endtask

  task automatic test_div_zero();
    int lat; logic er; logic [31:0] q, r; logic dz;
    start_op(32'h1234_5678, 32'd0, 1'b0);
    wait_valid(1, lat, er, q, r, dz);
    $display("op divzero lat=%0d q=%h r=%h dz=%b", lat, q, r, dz);
    checks++; if (lat !== 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'h1234_5678) begin failures++;
      $display("FAIL dbz_result got=%h/%h exp=ffffffff/12345678", q, r); end
    checks++; if (dz !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", dz); end
  endtask

  task automatic test_overflow();
    int lat; logic er; logic [31:0] q, r; logic dz;
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_valid(1, lat, er, q, r, dz);
    $display("op overflow lat=%0d q=%h r=%h dz=%b", lat, q, r, dz);
    checks++; if (lat !== 1) begin failures++; $display("FAIL ovf_latency got=%0d exp=1", lat); end
    checks++; if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0) begin failures++;
      $display("FAIL ovf_result got=%h/%h/%b exp=80000000/0/0", q, r, dz); end
  endtask

  task automatic test_unit_and_zero();
    int lat; logic er; logic [31:0] q, r; logic dz; logic [31:0] a;
    for (int i = 0; i < 2; i++) begin
      a = $urandom;
      start_op(a, 32'd1, 1'(i));
      wait_valid(1, lat, er, q, r, dz);
      $display("op unit s=%0d a=%h lat=%0d q=%h r=%h", i, a, lat, q, r);
      checks++; if (lat !== 34 || q !== a || r !== 32'd0) begin failures++;
        $display("FAIL div_by_one got=%h/%h lat=%0d exp=%h/0 lat=34", q, r, lat, a); end
    end
    start_op(32'd0, 32'hFFFF_FFF3, 1'b1);
    wait_valid(1, lat, er, q, r, dz);
    $display("op zero_dividend lat=%0d q=%h r=%h", lat, q, r);
    checks++; if (lat !== 34 || q !== 32'd0 || r !== 32'd0) begin failures++;
      $display("FAIL zero_dividend got=%h/%h lat=%0d exp=0/0 lat=34", q, r, lat); end
  endtask

  // data_valid_i while busy must be ignored and the latched operands kept.
  task automatic test_ignore_busy();
    int lat; logic er; logic [31:0] q, r; logic dz;
    start_op(32'd1000, 32'd10, 1'b0);
    dividend_i = 32'd5; divisor_i = 32'd0; signed_i = 1'b1; data_valid_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    data_valid_i = 1'b0;
    wait_valid(6, lat, er, q, r, dz);
    $display("op busy_ignore lat=%0d q=%h r=%h", lat, q, r);
    checks++; if (lat !== 34 || q !== 32'd100 || r !== 32'd0 || dz !== 1'b0) begin failures++;
      $display("FAIL busy_ignore got=%h/%h/%b lat=%0d exp=64/0/0 lat=34", q, r, dz, lat); end
  endtask

  task automatic test_back_to_back();
    int lat; logic er; logic [31:0] q, r, eq, er_v; logic dz, edz; int elat;
    logic [31:0] a; logic [31:0] b;
    start_op(32'd50, 32'd6, 1'b0);
    wait_valid(1, lat, er, q, r, dz);
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom_range(1, 1000);
      model(a, b, 1'b0, eq, er_v, edz, elat);
      @(posedge clk); #1;       // cycle right after DONE
      checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", ready_o); end
      dividend_i = a; divisor_i = b; signed_i = 1'b0; data_valid_i = 1'b1;
      @(posedge clk); #1;
      data_valid_i = 1'b0;
      wait_valid(1, lat, er, q, r, dz);
      $display("op b2b a=%h b=%h lat=%0d q=%h r=%h", a, b, lat, q, r);
      checks++; if (lat !== elat || q !== eq || r !== er_v) begin failures++;
        $display("FAIL b2b_result got=%h/%h lat=%0d exp=%h/%h lat=%0d", q, r, lat, eq, er_v, elat); end
    end
  endtask

  task automatic test_abort();
    int lat; logic er; logic [31:0] q, r; logic dz;
    start_op(32'd1000, 32'd10, 1'b0);
    wait_valid(1, lat, er, q, r, dz);
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    abort_i = 1'b1;            // DIVIDE cycle 10
    @(posedge clk); #1;
    abort_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", ready_o); end
    checks++; if (quotient_o !== 32'd100 || remainder_o !== 32'd0 || divide_by_zero_o !== 1'b0) begin failures++;
      $display("FAIL abort_outputs_held got=%h/%h/%b exp=64/0/0", quotient_o, remainder_o, divide_by_zero_o); end
    wait_valid(11, lat, er, q, r, dz);
    $display("op aborted lat=%0d", lat);
    checks++; if (lat !== -1) begin failures++; $display("FAIL abort_no_strobe got=%0d exp=-1", lat); end
    start_op(32'd9, 32'd3, 1'b0);
    wait_valid(1, lat, er, q, r, dz);
    $display("op after_abort 9/3 lat=%0d q=%h r=%h", lat, q, r);
    checks++; if (lat !== 34 || q !== 32'd3 || r !== 32'd0) begin failures++;
      $display("FAIL after_abort got=%h/%h lat=%0d exp=3/0 lat=34", q, r, lat); end
  endtask

  task automatic test_abort_done();
    int lat; logic er; logic [31:0] q, r; logic dz;
    start_op(32'h1234_5678, 32'd0, 1'b0);
    wait_valid(1, lat, er, q, r, dz);
    abort_i = 1'b1;            // still in the DONE cycle
    #1;
    checks++; if (data_valid_o !== 1'b1) begin failures++; $display("FAIL abort_in_done got=%b exp=1", data_valid_o); end
    @(posedge clk); #1;
    abort_i = 1'b0;
    checks++; if (quotient_o !== 32'hFFFF_FFFF || divide_by_zero_o !== 1'b1) begin failures++;
      $display("FAIL abort_done_result got=%h/%b exp=ffffffff/1", quotient_o, divide_by_zero_o); end
  endtask

  task automatic test_abort_idle();
    int lat; logic er; logic [31:0] q, r; logic dz;
    @(posedge clk); #1;
    dividend_i = 32'd5; divisor_i = 32'd0; signed_i = 1'b0; data_valid_i = 1'b1; abort_i = 1'b1;
    @(posedge clk); #1;
    data_valid_i = 1'b0; abort_i = 1'b0;
    checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL abort_idle_ready got=%b exp=1", ready_o); end
    wait_valid(1, lat, er, q, r, dz);
    $display("op abort_idle lat=%0d", lat);
    checks++; if (lat !== -1) begin failures++; $display("FAIL abort_idle_no_accept got=%0d exp=-1", lat); end
    checks++; if (remainder_o !== 32'h1234_5678) begin failures++;
      $display("FAIL abort_idle_held got=%h exp=12345678", remainder_o); end
  endtask

  task automatic test_reset_mid();
    int lat; logic er; logic [31:0] q, r; logic dz;
    start_op(32'd100, 32'd7, 1'b0);
    wait_valid(1, lat, er, q, r, dz);
    start_op(32'd5000, 32'd3, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;              // DIVIDE cycle 5, away from any clock edge
    #1;
    checks++; if (quotient_o !== 32'd0 || remainder_o !== 32'd0 || divide_by_zero_o !== 1'b0) begin failures++;
      $display("FAIL async_reset_outputs got=%h/%h/%b exp=0/0/0", quotient_o, remainder_o, divide_by_zero_o); end
    checks++; if (data_valid_o !== 1'b0 || ready_o !== 1'b1) begin failures++;
      $display("FAIL async_reset_handshake got valid=%b ready=%b exp valid=0 ready=1", data_valid_o, ready_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid(1, lat, er, q, r, dz);
    $display("op reset_mid lat=%0d", lat);
    checks++; if (lat !== -1) begin failures++; $display("FAIL reset_mid_no_strobe got=%0d exp=-1", lat); end
  endtask

  task automatic test_random();
    int lat; logic er; logic [31:0] q, r; logic dz;
    logic [31:0] a, b, eq, erm; logic s, edz; int elat; int mode;
    for (int i = 0; i < 40; i++) begin
      a = $urandom; s = 1'($urandom_range(0, 1)); mode = $urandom_range(0, 9);
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1'b1; end
        2: b = $urandom_range(1, 15);
        3: b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(a, b, s, eq, erm, edz, elat);
      start_op(a, b, s);
      wait_valid(1, lat, er, q, r, dz);
      $display("op rand%0d s=%0d a=%h b=%h lat=%0d q=%h r=%h dz=%b", i, s, a, b, lat, q, r, dz);
      checks++;
      if (lat !== elat || q !== eq || r !== erm || dz !== edz || er !== 1'b0) begin failures++;
        $display("FAIL random_%0d got=%h/%h/%b lat=%0d exp=%h/%h/%b lat=%0d", i, q, r, dz, lat, eq, erm, edz, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_unit_and_zero();
    test_ignore_busy();
    test_back_to_back();
    test_abort();
    test_abort_done();
    test_abort_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/non_restoring_divider.md
NON_RESTORING_DIVIDER -- requirements
Module: non_restoring_divider

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter DATA_WIDTH, default XLEN (32), which sets the operand and result width.
REQ-003 The block SHALL have port clk_i, input, 1, the system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port data_valid_i, input, 1, which marks the operands as valid this cycle.
REQ-006 The block SHALL have port dividend_i, input, DATA_WIDTH, the dividend.
REQ-007 The block SHALL have port divisor_i, input, DATA_WIDTH, the divisor.
REQ-008 The block SHALL have port signed_i, input, 1: 1 selects DIV/REM two's-complement semantics, 0 selects DIVU/REMU.
REQ-009 The block SHALL have port abort_i, input, 1, a pipeline flush that cancels the operation in flight.
REQ-010 The block SHALL have port quotient_o, output, DATA_WIDTH, the registered quotient.
REQ-011 The block SHALL have port remainder_o, output, DATA_WIDTH, the registered remainder.
REQ-012 The block SHALL have port divide_by_zero_o, output, 1, a flag qualified by data_valid_o.
REQ-013 The block SHALL have port data_valid_o, output, 1, a one-cycle result strobe.
REQ-014 The block SHALL have port ready_o, output, 1, which is high when a new operation can be accepted.

Function
REQ-015 The FSM SHALL have states IDLE, DIVIDE, FIXUP and DONE; ready_o SHALL be 1 only in IDLE, and data_valid_o SHALL be 1 only in DONE.
REQ-016 The accept cycle SHALL be any IDLE cycle with data_valid_i=1 and abort_i=0; operands and signed_i SHALL be latched on that edge, and data_valid_i SHALL be ignored outside IDLE.
REQ-017 In the accept cycle, if divisor_i=0, the FSM SHALL go IDLE->DONE, with quotient all ones, remainder = dividend_i and divide_by_zero_o=1.
REQ-018 In the accept cycle, if signed_i=1, dividend_i=0x80000000 and divisor_i=0xFFFFFFFF, the FSM SHALL go IDLE->DONE, with quotient 0x80000000, remainder 0 and divide_by_zero_o=0.
REQ-019 Otherwise, the accept cycle SHALL go IDLE->DIVIDE; the iteration counter SHALL be loaded with DATA_WIDTH-1, and magnitudes SHALL be taken when signed_i=1.
REQ-020 DIVIDE SHALL perform one non-restoring step per cycle: if the partial remainder is >= 0, shift and subtract the divisor magnitude, else shift and add; the quotient bit SHALL be the inverted sign of the new partial remainder.
REQ-021 The partial remainder register SHALL be DATA_WIDTH+1 bits wide.
REQ-022 DIVIDE SHALL last exactly DATA_WIDTH cycles; when the counter reaches 0 the FSM SHALL go DIVIDE->FIXUP.
REQ-023 FIXUP, one cycle, SHALL add the divisor magnitude back if the partial remainder is negative.
REQ-024 FIXUP SHALL negate the quotient if signed and the operand signs differ, and SHALL negate the remainder if signed and the dividend is negative (remainder takes the dividend's sign); it SHALL then go FIXUP->DONE.
REQ-025 DONE SHALL last one cycle, then go DONE->IDLE; a back-to-back accept SHALL be possible in the cycle after DONE.
REQ-026 Latency SHALL be: normal operation, data_valid_o in cycle accept+DATA_WIDTH+2 (34 for 32 bits); special cases, data_valid_o in cycle accept+1.
REQ-027 quotient_o, remainder_o and divide_by_zero_o SHALL hold their last result until the next DONE.
REQ-028 An abort_i=1 in DIVIDE or FIXUP SHALL force IDLE on the next edge; no data_valid_o pulse SHALL follow, and outputs SHALL keep their previous values.
REQ-029 An abort_i=1 in DONE SHALL NOT suppress the strobe already asserted in that cycle.
REQ-030 An abort_i=1 together with data_valid_i in IDLE SHALL cause no accept.
REQ-031 A divisor of 1 and a dividend of 0 SHALL take the normal path and produce correct results (quotient = dividend, remainder 0, and quotient 0, remainder 0, respectively).

Reset
REQ-032 When rst_n_i=0, asynchronously and regardless of clock: the state SHALL be IDLE, the counter 0, quotient_o 0, remainder_o 0, divide_by_zero_o 0, data_valid_o 0 and ready_o 1.
REQ-033 A reset mid-operation SHALL discard the operation, and no data_valid_o SHALL follow.
REQ-034 After reset deassertion, the first rising edge SHALL be able to accept an operation.

Verification
REQ-035 The bench SHALL check: unsigned 100 / 7 -> quotient 14, remainder 2, data_valid_o exactly 34 cycles after accept, ready_o low throughout.
REQ-036 The bench SHALL check: signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); and signed 7 / -2 -> quotient -3, remainder 1.
REQ-037 The bench SHALL check: divisor 0 with dividend 0x12345678 -> quotient 0xFFFFFFFF, remainder 0x12345678, divide_by_zero_o=1, data_valid_o one cycle after accept.
REQ-038 The bench SHALL check: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, data_valid_o one cycle after accept.
REQ-039 The bench SHALL check: abort_i pulsed at DIVIDE cycle 10 -> ready_o 1 next cycle, no data_valid_o, outputs unchanged; a new 9 / 3 operation then yields quotient 3, remainder 0.
REQ-040 The bench SHALL check: rst_n_i low at DIVIDE cycle 5 -> all outputs at reset values immediately, and no strobe after release.
